// File: rtl/muldiv32.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiply and restoring divide,
// with signed operands handled as magnitudes plus a final sign correction.
module muldiv32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             oZero,
    output logic             oDivZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 sgn1_q, sgn1_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     out_lo_q, out_lo_d;
    logic [WIDTH-1:0]     out_hi_q, out_hi_d;
    logic                 zero_q, zero_d;
    logic                 divz_q, divz_d;

    logic                 s1, s2;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // One shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole accumulator (carry included) right by one.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // One restoring step: remainder in the high half, dividend/quotient bits in the low half.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] rsh;
        logic [WIDTH:0] diff;
        rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = rsh - {1'b0, d};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        return {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
            zero_q   <= zero_d;
            divz_q   <= divz_d;
        end
    end

    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        sgn1_q   <= sgn1_d;
        b_q      <= b_d;
        acc_q    <= acc_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sgn1_d   = sgn1_q;
        b_d      = b_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        zero_d   = zero_q;
        divz_d   = divz_q;
        busy     = (state_q != S_IDLE);

        s1   = op[0] & data1[WIDTH-1];
        s2   = op[0] & data2[WIDTH-1];
        prod = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        quo  = magnitude(acc_q[WIDTH-1:0], neg_q);
        rem  = magnitude(acc_q[2*WIDTH-1:WIDTH], sgn1_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = s1 ^ s2;
                    sgn1_d   = s1;
                    b_d      = magnitude(data2, s2);
                    acc_d    = {{WIDTH{1'b0}}, magnitude(data1, s1)};
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_step(acc_q, b_q) : mul_step(acc_q, b_q);
                cnt_d = cnt_q + CW'(1);
            end
            S_FIN: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    // Zero divisor leaves the dividend magnitude as remainder, so the
                    // remainder sign fix-up restores the original data1 bit pattern.
                    out_lo_d = (b_q == '0) ? '1 : quo;
                    out_hi_d = rem;
                    zero_d   = (b_q != '0) && (quo == '0);
                    divz_d   = (b_q == '0);
                end else begin
                    out_lo_d = prod[WIDTH-1:0];
                    out_hi_d = prod[2*WIDTH-1:WIDTH];
                    zero_d   = (prod == '0);
                    divz_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign done     = done_q;
    assign out_lo   = out_lo_q;
    assign out_hi   = out_hi_q;
    assign oZero    = zero_q;
    assign oDivZero = divz_q;

endmodule

// File: doc/muldiv32.md
# muldiv32

Iterative 32-bit multiply/divide unit for the execute stage of the processor. It takes the same two operands that feed the ALU and runs alongside it, so the design gains multiply, divide and remainder operations without lengthening the ALU's combinational path. Results go to the write-back mux next to the ALU result. A start/busy/done handshake lets the control unit stall while an operation is in flight.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Products are 2·WIDTH bits wide.

Ports:
- `clk`  input  1  system clock; every register updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request a new operation. Sampled only while `busy`=0.
- `op`  input  2  operation, sampled together with `start`:
  - 00 MULU, unsigned multiply
  - 01 MUL, signed multiply
  - 10 DIVU, unsigned divide
  - 11 DIV, signed divide
- `data1`  input  WIDTH  multiplicand or dividend.
- `data2`  input  WIDTH  multiplier or divisor.
- `busy`  output  1  operation in progress. Inputs are ignored while high.
- `done`  output  1  one-cycle pulse when `out_lo` and `out_hi` become valid.
- `out_lo`  output  WIDTH  low half of the product, or the quotient.
- `out_hi`  output  WIDTH  high half of the product, or the remainder.
- `oZero`  output  1  result is zero:
  - for a multiply, the full {`out_hi`,`out_lo`} is 0
  - for a divide, `out_lo` is 0
- `oDivZero`  output  1  the last divide had `data2`=0.

## Operation

States and transitions:
- **IDLE**: `start`=1 latches `op` and the magnitudes of `data1`/`data2`, and also latches the operand signs for signed ops. It clears the iteration counter and moves to RUN.
- **RUN**: performs one iteration per cycle, for exactly WIDTH cycles, then moves to FIN.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract. The quotient builds up in the low half and the remainder in the high half.
- **FIN**: applies sign correction, registers the outputs, pulses `done`, and returns to IDLE.

Arithmetic rules:
- MUL: the product is negated if the operand signs differ. The full 2·WIDTH result is exact.
- DIV: the quotient truncates toward zero, is negated if the signs differ, and the remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned:
  - `out_lo` = all ones and `out_hi` = `data1` unmodified
  - `oDivZero`=1
  - full latency still applies
- Signed overflow (−2^(WIDTH−1) / −1): `out_lo` = 0x80000000, `out_hi` = 0, `oDivZero`=0.
- `oDivZero` is cleared by any multiply completion and by any divide with a nonzero divisor.

Output behaviour:
- Outputs hold their value from one `done` to the next. They do not change during RUN.
- `start` while `busy`=1 is ignored: it is neither queued nor allowed to corrupt the operation in flight.

Reset:
- `rst_n`=0 at any time forces IDLE immediately. This includes mid-RUN, which aborts the operation with no `done`.
- Reset values: `busy`=0, `done`=0, `out_lo`=0, `out_hi`=0, `oZero`=0, `oDivZero`=0.

## Timing

- E0 is the edge that samples `start`=1 in IDLE.
- After E0: `busy`=1.
- Edges E1–E32: the 32 RUN iterations. After E32 the state is FIN.
- After E33: `done`=1 for one cycle, results are valid, `busy`=0, and the state is IDLE.
- Latency is WIDTH+1 = 33 cycles from E0 to valid results.
- `busy` is 0 in the cycle where `done`=1. `start`=1 in that cycle is accepted, which gives a back-to-back throughput of one op per 33 cycles.
- `done` never stays high for two consecutive cycles.
- Operands must be stable only at the sampling edge.
- Outputs are fully registered, with no combinational path from inputs to outputs.

## Test plan

- MULU 7 × 6 → `done` exactly 33 cycles after `start`; `out_hi`=0, `out_lo`=42, `oZero`=0. Also MULU 0xFFFFFFFF × 0xFFFFFFFF → `out_hi`=0xFFFFFFFE, `out_lo`=0x00000001.
- MUL −3 × 5 → `out_hi`=0xFFFFFFFF, `out_lo`=0xFFFFFFF1. Also MUL 0 × −9 → `oZero`=1.
- DIVU 100 / 7 → `out_lo`=14, `out_hi`=2. Also DIV −7 / 2 → `out_lo`=0xFFFFFFFD, `out_hi`=0xFFFFFFFF. Also DIV 0x80000000 / −1 → `out_lo`=0x80000000, `out_hi`=0.
- DIVU 5 / 0 → `out_lo`=0xFFFFFFFF, `out_hi`=5, `oDivZero`=1. A following MULU 2 × 2 clears `oDivZero`.
- `start` pulsed at cycle 10 of a running op with different operands → the first result is unaffected and only one `done` is seen. A new `start` in the `done` cycle → its `done` arrives 33 cycles later.
- `rst_n` low at cycle 15 of a DIVU → outputs go to 0 immediately, no `done` is seen, `busy`=0. After release, a new op completes normally.
